// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: instruction-fetch front end with a PC generator, a pipelined
// instruction-memory request port and a DEPTH-entry prefetch FIFO.
// Optional: define FETCH_BYPASS_EN so that a response arriving while the FIFO
// is empty goes straight to decode in the same cycle.
module rv_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_pc4
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] resp_pc_reg;
    logic [CW-1:0]   in_flight_reg;
    logic [CW-1:0]   drop_cnt_reg;
    logic [CW-1:0]   count_reg;
    logic            ignore_reg;     // stray responses from before reset
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [31:0]     hold_inst_reg;  // last instruction shown to decode
    logic [XLEN-1:0] hold_pc_reg;

    logic [31:0]     data_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    logic [CW:0]     credit_sum;
    logic            grant;
    logic            rsp;
    logic            keep;
    logic            bypass;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic [XLEN-1:0] redirect_aligned;

    // Credits cover FIFO slots plus outstanding requests, so a kept response
    // always finds room.
    assign credit_sum       = {1'b0, in_flight_reg} + {1'b0, count_reg};
    assign imem_req         = !rst && !redirect && (credit_sum < (CW+1)'(DEPTH));
    assign imem_addr        = rst ? RESET_PC : fetch_pc_reg;
    assign grant            = imem_req && imem_gnt;
    assign rsp              = imem_rvalid && !ignore_reg && !rst;
    assign keep             = rsp && (drop_cnt_reg == '0);
    assign fifo_empty       = (count_reg == '0);
    assign redirect_aligned = redirect_pc & ~XLEN'(3);

`ifdef FETCH_BYPASS_EN
    assign bypass = fifo_empty && keep && inst_ready && !redirect;
`else
    assign bypass = 1'b0;
`endif

    assign push = keep && !redirect && !bypass;
    assign pop  = !fifo_empty && inst_ready && !redirect;

    // Decode-side view: FIFO head, bypassed response, or the held last value.
    always_comb begin
        inst_valid = 1'b0;
        inst       = hold_inst_reg;
        inst_pc    = hold_pc_reg;
        if (rst) begin
            inst    = '0;
            inst_pc = '0;
        end else if (!fifo_empty) begin
            inst_valid = 1'b1;
            inst       = data_mem[rd_ptr_reg];
            inst_pc    = pc_mem[rd_ptr_reg];
        end else if (bypass) begin
            inst_valid = 1'b1;
            inst       = imem_rdata;
            inst_pc    = resp_pc_reg;
        end
    end

    assign inst_pc4 = inst_pc + PC_STEP;

    // FIFO storage write port (no reset needed on the data array).
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= imem_rdata;
            pc_mem[wr_ptr_reg]   <= resp_pc_reg;
        end
    end

    // PC generator, request/response bookkeeping and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg  <= RESET_PC;
            resp_pc_reg   <= RESET_PC;
            in_flight_reg <= '0;
            drop_cnt_reg  <= '0;
            count_reg     <= '0;
            ignore_reg    <= 1'b1;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            hold_inst_reg <= '0;
            hold_pc_reg   <= '0;
        end else if (redirect) begin
            // Everything still in flight belongs to the old stream.
            fetch_pc_reg  <= redirect_aligned;
            resp_pc_reg   <= redirect_aligned;
            in_flight_reg <= in_flight_reg - CW'(rsp);
            drop_cnt_reg  <= in_flight_reg - CW'(rsp);
            count_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            if (!fifo_empty) begin
                hold_inst_reg <= data_mem[rd_ptr_reg];
                hold_pc_reg   <= pc_mem[rd_ptr_reg];
            end
        end else begin
            if (grant) begin
                fetch_pc_reg <= fetch_pc_reg + PC_STEP;
                ignore_reg   <= 1'b0;
            end
            in_flight_reg <= in_flight_reg + CW'(grant) - CW'(rsp);
            if (rsp) begin
                if (drop_cnt_reg != '0) begin
                    drop_cnt_reg <= drop_cnt_reg - CW'(1);
                end else begin
                    resp_pc_reg <= resp_pc_reg + PC_STEP;
                end
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg    <= rd_ptr_reg + AW'(1);
                hold_inst_reg <= data_mem[rd_ptr_reg];
                hold_pc_reg   <= pc_mem[rd_ptr_reg];
            end else if (bypass) begin
                hold_inst_reg <= imem_rdata;
                hold_pc_reg   <= resp_pc_reg;
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed testbench for rv_fetch_unit (XLEN=32, DEPTH=4, RESET_PC=0) with a
// small in-order instruction-memory model of programmable latency.
module tb_rv_fetch_unit;

`ifdef FETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;
    int lat     = 1;
    bit gnt_en  = 1'b0;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] got[$];
    logic [31:0] got_pc4[$];
    int          got_cyc[$];
    logic [31:0] req_log[$];
    int          req_cyc[$];

    logic        req_seen;
    logic        valid_seen;
    logic [31:0] addr_seen;
    bit          any_valid;

    rv_fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: memory model drives its outputs, DUT settles, the bench
    // logs grants/consumed instructions, then advances past the next edge.
    task automatic step();
        logic [31:0] p4;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        imem_gnt = gnt_en;
        #1;
        if (imem_rvalid) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (imem_req && imem_gnt) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + lat);
            req_log.push_back(imem_addr);
            req_cyc.push_back(cyc);
        end
        if (inst_valid && inst_ready && !redirect) begin
            p4 = inst_pc + 32'd4;
            $display("cyc %0d inst pc=%08h word=%08h", cyc, inst_pc, inst);
            got.push_back(inst_pc);
            got_pc4.push_back(inst_pc4);
            got_cyc.push_back(cyc);
            check_value("inst_word", inst, mem_word(inst_pc));
            check_value("inst_pc4", inst_pc4, p4);
        end
        req_seen   = imem_req;
        valid_seen = inst_valid;
        addr_seen  = imem_addr;
        if (inst_valid) any_valid = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_logs();
        got.delete();
        got_pc4.delete();
        got_cyc.delete();
        req_log.delete();
        req_cyc.delete();
    endtask

    // Holds reset long enough for any outstanding responses to drain.
    task automatic do_reset();
        rst        = 1'b1;
        gnt_en     = 1'b0;
        redirect   = 1'b0;
        inst_ready = 1'b0;
        repeat (4) step();
        check_value("rst_req", imem_req, 0);
        check_value("rst_valid", inst_valid, 0);
        check_value("rst_addr", imem_addr, 32'h0);
        check_value("rst_inst", inst, 0);
        check_value("rst_pc", inst_pc, 0);
        pend_addr.delete();
        pend_due.delete();
        clear_logs();
    endtask

    initial begin
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

        // 1: streaming with 1-cycle memory
        do_reset();
        rst = 1'b0; inst_ready = 1'b1; gnt_en = 1'b1; lat = 1;
        repeat (8) step();
        check_value("t1_addr0", req_log[0], 32'h0);
        check_value("t1_addr1", req_log[1], 32'h4);
        check_value("t1_addr2", req_log[2], 32'h8);
        check_value("t1_addr3", req_log[3], 32'hC);
        check_value("t1_count", got.size(), 6 + BYP);
        check_value("t1_pc0", got[0], 32'h0);
        check_value("t1_pc1", got[1], 32'h4);
        check_value("t1_pc2", got[2], 32'h8);
        check_value("t1_rate", got_cyc[2] - got_cyc[0], 2);
        check_value("t1_latency", got_cyc[0] - req_cyc[0], 2 - BYP);

        // 2: backpressure fills the FIFO, then drains in order
        do_reset();
        rst = 1'b0; inst_ready = 1'b0; gnt_en = 1'b1; lat = 1;
        repeat (10) step();
        check_value("t2_grants", req_log.size(), 4);
        check_value("t2_req_off", req_seen, 0);
        check_value("t2_valid", inst_valid, 1);
        check_value("t2_head", inst_pc, 32'h0);
        check_value("t2_none_taken", got.size(), 0);
        inst_ready = 1'b1;
        repeat (12) step();
        check_value("t2_drained", got.size() >= 8, 1);
        for (int i = 0; i < got.size(); i++) check_value("t2_order", got[i], 32'(4 * i));

        // 3: 3-cycle memory, redirect with 3 outstanding to unaligned target
        do_reset();
        rst = 1'b0; inst_ready = 1'b1; gnt_en = 1'b1; lat = 3;
        repeat (3) step();
        check_value("t3_outstanding", req_log.size(), 3);
        redirect = 1'b1; redirect_pc = 32'h103;
        step();
        check_value("t3_req_in_redirect", req_seen, 0);
        redirect = 1'b0;
        repeat (15) step();
        check_value("t3_new_addr", req_log[3], 32'h100);
        check_value("t3_new_req_cyc", req_cyc[3] - req_cyc[2], 2);
        check_value("t3_count", got.size() >= 2, 1);
        check_value("t3_pc0", got[0], 32'h100);
        check_value("t3_pc1", got[1], 32'h104);

        // 4: redirect coinciding with pop and rvalid, count=2
        do_reset();
        rst = 1'b0; inst_ready = 1'b0; gnt_en = 1'b1; lat = 1;
        repeat (3) step();
        inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        step();
        check_value("t4_empty_after", valid_seen, 0);
        check_value("t4_addr", addr_seen, 32'h200);
        repeat (6) step();
        check_value("t4_count", got.size() >= 2, 1);
        for (int i = 0; i < got.size(); i++) check_value("t4_stream", got[i], 32'h200 + 32'(4 * i));

        // 5: address wrap at 2^32
        do_reset();
        rst = 1'b0; inst_ready = 1'b1; gnt_en = 1'b1; lat = 1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        repeat (6) step();
        check_value("t5_addr_top", req_log[0], 32'hFFFF_FFFC);
        check_value("t5_addr_wrap", req_log[1], 32'h0);
        check_value("t5_pc_top", got[0], 32'hFFFF_FFFC);
        check_value("t5_pc4_wrap", got_pc4[0], 32'h0);
        check_value("t5_pc_next", got[1], 32'h0);

        // 6: reset with 2 in flight, stray responses afterwards
        do_reset();
        rst = 1'b0; inst_ready = 1'b1; gnt_en = 1'b1; lat = 1;
        redirect = 1'b1; redirect_pc = 32'h300;
        step();
        redirect = 1'b0; lat = 3;
        repeat (2) step();
        check_value("t6_inflight", req_log.size(), 2);
        rst = 1'b1; gnt_en = 1'b0;
        step();
        rst = 1'b0; any_valid = 1'b0;
        clear_logs();
        repeat (3) step();
        check_value("t6_stray_valid", any_valid, 0);
        check_value("t6_stray_taken", got.size(), 0);
        gnt_en = 1'b1; lat = 1;
        repeat (6) step();
        check_value("t6_first_pc", got[0], 32'h0);
        check_value("t6_first_lat", got_cyc[0] - req_cyc[0], 2 - BYP);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
